// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and elaboration-time helpers for the
// sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int         DIGIT_W     = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;
  localparam logic [3:0] BCD_NINE    = 4'h9;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_nibble_adj.sv
// Double-dabble correction for one BCD nibble: add 3 when the digit is 5 or
// more, so that the following left shift carries correctly into the next digit.
module bcd_nibble_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] nib_in,
  output logic [DIGIT_W-1:0] nib_out
);

  assign nib_out = (nib_in >= ADD3_THRESH) ? nib_in + DIGIT_W'(3) : nib_in;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: BIN_W-bit binary in, DIGITS packed BCD
// digits out, one input bit per clock, saturating to all nines on overflow.
//
// state | meaning
// IDLE  | ready=1, waiting for start; last result held on bcd_out/overflow
// CONV  | shifting one binary bit per clock into the BCD accumulator
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  ready,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int                ACC_W    = DIGIT_W * DIGITS;
  localparam int                CNT_W    = $clog2(BIN_W + 1);
  localparam int unsigned       POW10_D  = pow10(DIGITS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BIN_W - 1);
  localparam logic [ACC_W-1:0]  SAT_VAL  = {DIGITS{BCD_NINE}};

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_lat_q, ovf_lat_d;
  logic [ACC_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               valid_q, valid_d;

  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_shift;
  logic               in_ovf;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_nibble_adj u_adj (
      .nib_in  (acc_q[g*DIGIT_W +: DIGIT_W]),
      .nib_out (acc_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Bits pushed out of the accumulator top are dropped; overflow saturation
  // hides any result that would have needed them.
  assign acc_shift = (acc_adj << 1) | ACC_W'(bin_q[BIN_W-1]);
  assign in_ovf    = (32'(bin_in) >= POW10_D);

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_lat_d = ovf_lat_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = CONV;
          bin_d     = bin_in;
          acc_d     = '0;
          cnt_d     = '0;
          ovf_lat_d = in_ovf;
        end
      end
      CONV: begin
        acc_d = acc_shift;
        bin_d = bin_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          bcd_d   = ovf_lat_q ? SAT_VAL : acc_shift;
          ovf_d   = ovf_lat_q;
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_lat_q <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_lat_q <= ovf_lat_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
    end
  end

  assign ready    = (state_q == IDLE);
  assign valid    = valid_q;
  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: hand-computed BCD results, latency,
// handshake and reset-abort behaviour.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  bin_in;
  logic        ready;
  logic        valid;
  logic [11:0] bcd_out;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  bin_to_bcd_seq #(.BIN_W(10), .DIGITS(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin_in   (bin_in),
    .ready    (ready),
    .valid    (valid),
    .bcd_out  (bcd_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts rising edges until valid is seen; also reports whether bcd_out
  // stayed at its entry value on every cycle before the valid one.
  task automatic wait_valid(output int lat, output bit held);
    logic [11:0] entry;
    entry = bcd_out;
    held  = 1'b1;
    lat   = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid) begin
        lat = k;
        break;
      end
      if (bcd_out !== entry) held = 1'b0;
    end
  endtask

  task automatic run_conv(input string tag, input logic [9:0] val,
                          input logic [11:0] exp_bcd, input logic exp_ovf);
    int lat;
    bit held;
    bin_in = val;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    bin_in = 10'h3ff;
    wait_valid(lat, held);
    chk({tag, "_lat"}, lat, 10);
    chk({tag, "_bcd"}, {20'h0, bcd_out}, {20'h0, exp_bcd});
    chk({tag, "_ovf"}, {31'h0, overflow}, {31'h0, exp_ovf});
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_vpulse"}, {31'h0, valid}, 0);
  endtask

  initial begin
    int lat;
    bit held;
    int vcount;

    rst_n  = 1'b0;
    start  = 1'b1;
    bin_in = 10'd5;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'h0, ready}, 1);
    chk("rst_valid", {31'h0, valid}, 0);
    chk("rst_bcd", {20'h0, bcd_out}, 0);
    chk("rst_ovf", {31'h0, overflow}, 0);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_idle", {31'h0, ready}, 1);

    run_conv("c0", 10'd0, 12'h000, 1'b0);
    run_conv("c255", 10'd255, 12'h255, 1'b0);
    run_conv("c999", 10'd999, 12'h999, 1'b0);
    run_conv("c1000", 10'd1000, 12'h999, 1'b1);
    run_conv("c1023", 10'd1023, 12'h999, 1'b1);
    run_conv("c7", 10'd7, 12'h007, 1'b0);
    run_conv("c680", 10'd680, 12'h680, 1'b0);

    // start during CONV must be ignored
    @(negedge clk);
    bin_in = 10'd123;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      chk($sformatf("ign_ready_c%0d", i), {31'h0, ready}, 0);
      chk($sformatf("ign_valid_c%0d", i), {31'h0, valid}, 0);
      if (i == 3) begin
        start  = 1'b1;
        bin_in = 10'd456;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    chk("ign_valid", {31'h0, valid}, 1);
    chk("ign_bcd", {20'h0, bcd_out}, 32'h123);
    vcount = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid) vcount++;
    end
    chk("ign_no_second", vcount, 0);
    chk("ign_bcd_hold", {20'h0, bcd_out}, 32'h123);

    // back-to-back: start held high in the valid cycle
    bin_in = 10'd123;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_valid(lat, held);
    chk("b2b_first_lat", lat, 10);
    chk("b2b_first_bcd", {20'h0, bcd_out}, 32'h123);
    chk("b2b_ready_in_valid", {31'h0, ready}, 1);
    bin_in = 10'd42;
    start  = 1'b1;
    @(posedge clk);
    wait_valid(lat, held);
    start = 1'b0;
    chk("b2b_lat", lat, 10);
    chk("b2b_hold", {31'h0, held}, 1);
    chk("b2b_bcd", {20'h0, bcd_out}, 32'h042);

    // reset in the middle of a conversion
    @(negedge clk);
    bin_in = 10'd500;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_valid", {31'h0, valid}, 0);
    chk("abort_bcd", {20'h0, bcd_out}, 0);
    chk("abort_ready", {31'h0, ready}, 1);
    rst_n  = 1'b1;
    vcount = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid) vcount++;
    end
    chk("abort_no_valid", vcount, 0);
    chk("abort_ready_after", {31'h0, ready}, 1);
    run_conv("c500", 10'd500, 12'h500, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
